i2c_target_core: RTL and testbench

//  I2C target (slave) byte engine: the responder counterpart to i2c_core. Detects START/STOP,

---
 rtl/i2c_target_core.sv | 228 ++++++++++++++++++++++
 tb/tb_i2c_target_core.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_core.sv
// i2c_target_core: I2C target byte engine. Detects START/STOP, matches a 7-bit
// address, ACKs and delivers written bytes, and serves read bytes from local logic.
// SCL/SDA outputs are open-drain style (0 = pull low, 1 = release).
// Optional build macro I2C_TARGET_CLK_STRETCH_EN: stretch SCL when no read byte is
// ready at load time instead of sending TX_DEFAULT and pulsing tx_underrun.
module i2c_target_core #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter logic [7:0] TX_DEFAULT  = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_underrun,
  output logic       busy,
  output logic       rw
);

  localparam int unsigned BW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  state_t        state;
  logic          scl_q, sda_q;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [CW-1:0] bit_cnt;
  logic [BW-1:0] shreg, tx_shift, hold_data, hold_byte;
  logic          byte_done, hold_full, hold_avail, load_evt;
`ifdef I2C_TARGET_CLK_STRETCH_EN
  logic          stretch, rel_pend;
`endif

  assign scl_rise  = scl_i & ~scl_q;
  assign scl_fall  = ~scl_i & scl_q;
  assign start_det = scl_i & scl_q & sda_q & ~sda_i;
  assign stop_det  = scl_i & scl_q & ~sda_q & sda_i;

  // A strobe arriving in the load cycle is as good as a full holding register
  assign hold_avail = hold_full | tx_valid;
  assign hold_byte  = tx_valid ? tx_data : hold_data;
  assign load_evt   = scl_fall & (((state == ADDR_ACK) & rw) | (state == TX_ACK));

  // One-cycle history of the bus lines for edge and START/STOP detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_i;
      sda_q <= sda_i;
    end
  end

  // Protocol FSM with registered bus drives, data path and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      scl_o       <= 1'b1;
      sda_o       <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_req      <= 1'b0;
      tx_underrun <= 1'b0;
      busy        <= 1'b0;
      rw          <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      tx_shift    <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      byte_done   <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
      stretch     <= 1'b0;
      rel_pend    <= 1'b0;
`endif
    end else begin
      rx_valid    <= 1'b0;
      tx_req      <= 1'b0;
      tx_underrun <= 1'b0;
      if (tx_valid) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        sda_o     <= 1'b1;
        scl_o     <= 1'b1;
`ifdef I2C_TARGET_CLK_STRETCH_EN
        stretch   <= 1'b0;
        rel_pend  <= 1'b0;
`endif
      end else if (stop_det) begin
        state     <= IDLE;
        busy      <= 1'b0;
        byte_done <= 1'b0;
        sda_o     <= 1'b1;
        scl_o     <= 1'b1;
`ifdef I2C_TARGET_CLK_STRETCH_EN
        stretch   <= 1'b0;
        rel_pend  <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shreg   <= {shreg[BW-2:0], sda_i};
              bit_cnt <= bit_cnt + CW'(1);
              if (bit_cnt == CW'(7)) begin
                if (shreg[BW-2:0] == TARGET_ADDR) begin
                  rw        <= sda_i;
                  busy      <= 1'b1;
                  byte_done <= 1'b1;
                end else begin
                  busy  <= 1'b0;
                  state <= WAIT_STOP;
                end
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              sda_o     <= 1'b0;
              state     <= ADDR_ACK;
            end
          end
          RX: begin
            if (scl_rise) begin
              shreg   <= {shreg[BW-2:0], sda_i};
              bit_cnt <= bit_cnt + CW'(1);
              if (bit_cnt == CW'(7)) begin
                rx_data   <= {shreg[BW-2:0], sda_i};
                rx_valid  <= 1'b1;
                byte_done <= 1'b1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              sda_o     <= 1'b0;
              state     <= RX_ACK;
            end
          end
          ADDR_ACK: begin
            if (scl_rise && rw) tx_req <= 1'b1;
            if (scl_fall) begin
              sda_o   <= 1'b1;
              bit_cnt <= '0;
              state   <= rw ? TX : RX;
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              sda_o   <= 1'b1;
              bit_cnt <= '0;
              state   <= RX;
            end
          end
          TX: begin
            if (scl_fall) begin
              if (bit_cnt == CW'(7)) begin
                sda_o <= 1'b1;
                state <= TX_ACK;
              end else begin
                sda_o    <= tx_shift[BW-2];
                tx_shift <= {tx_shift[BW-2:0], 1'b0};
                bit_cnt  <= bit_cnt + CW'(1);
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (sda_i) state  <= WAIT_STOP;
              else       tx_req <= 1'b1;
            end
            if (scl_fall) begin
              bit_cnt <= '0;
              state   <= TX;
            end
          end
          WAIT_STOP: sda_o <= 1'b1;
          default:   state <= IDLE;
        endcase

        // Read byte load at the SCL fall that ends an ACK clock
        if (load_evt) begin
          if (hold_avail) begin
            tx_shift  <= hold_byte;
            sda_o     <= hold_byte[BW-1];
            hold_full <= 1'b0;
          end else begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
            scl_o   <= 1'b0;
            stretch <= 1'b1;
`else
            tx_shift    <= TX_DEFAULT;
            sda_o       <= TX_DEFAULT[BW-1];
            tx_underrun <= 1'b1;
`endif
          end
        end
`ifdef I2C_TARGET_CLK_STRETCH_EN
        // Deferred load while SCL is held; release SCL one cycle after the MSB is driven
        if (stretch && hold_avail) begin
          tx_shift  <= hold_byte;
          sda_o     <= hold_byte[BW-1];
          hold_full <= 1'b0;
          stretch   <= 1'b0;
          rel_pend  <= 1'b1;
        end
        if (rel_pend) begin
          scl_o    <= 1'b1;
          rel_pend <= 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_core.sv
// tb_i2c_target_core: directed bench driving an open-drain I2C bus model; DUT pulse
// outputs are checked by a scoreboard monitor against an expected-event queue.
`timescale 1ns/1ps
module tb_i2c_target_core;

  localparam int H = 8;
  localparam logic [1:0] K_RX   = 2'd0;
  localparam logic [1:0] K_TREQ = 2'd1;
  localparam logic [1:0] K_UND  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ctl_scl, ctl_sda;
  logic       scl_bus, sda_bus;
  logic       scl_o, sda_o;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, tx_underrun, busy, rw;
  logic [7:0] tx_data;
  logic       tx_valid;

  exp_t       exp_q[$];
  logic [7:0] reply_q[$];
  int         reply_dly = 1;
  int         n_cmp = 0;
  int         n_err = 0;
  int         sda_low_cnt = 0;
  int         c0;

  assign scl_bus = ctl_scl & scl_o;
  assign sda_bus = ctl_sda & sda_o;

  i2c_target_core dut (
    .clk(clk), .reset(reset), .scl_i(scl_bus), .sda_i(sda_bus),
    .scl_o(scl_o), .sda_o(sda_o), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_req(tx_req), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_underrun(tx_underrun), .busy(busy), .rw(rw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void expect_ev(input logic [1:0] k, input logic [7:0] v);
    exp_q.push_back({k, v});
  endfunction

  task automatic sb_pop(input logic [1:0] k, input logic [7:0] v, input string name);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got unexpected pulse (value %h), expected no event", name, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.val !== v) begin
        n_err++;
        $display("FAIL %s: got kind %0d value %h expected kind %0d value %h",
                 name, k, v, e.kind, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_up();
    int t;
    ctl_scl = 1'b1;
    t = 0;
    while (scl_bus !== 1'b1 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (scl_bus !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL scl_release: got scl held low for %0d cycles expected release", t);
    end
  endtask

  task automatic bus_start();
    ctl_sda = 1'b1; cyc(H);
    scl_up();       cyc(H);
    ctl_sda = 1'b0; cyc(H);
    ctl_scl = 1'b0; cyc(H);
  endtask

  task automatic bus_stop();
    ctl_sda = 1'b0; cyc(H);
    scl_up();       cyc(H);
    ctl_sda = 1'b1; cyc(H);
  endtask

  task automatic wr_bit(input logic b);
    ctl_sda = b; cyc(H);
    scl_up();    cyc(H);
    ctl_scl = 1'b0; cyc(H);
  endtask

  task automatic rd_bit(output logic b);
    ctl_sda = 1'b1; cyc(H);
    scl_up();       cyc(H/2);
    b = sda_bus;    cyc(H/2);
    ctl_scl = 1'b0; cyc(H);
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(a);
    chk(name, 8'(a), 8'(exp_ack));
  endtask

  task automatic rd_byte(input logic [7:0] exp_d, input logic ack_bit, input string name);
    logic [7:0] d;
    logic       b;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(ack_bit);
    chk(name, d, exp_d);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_scl_o"},       8'(scl_o),       8'd1);
    chk({tag, "_sda_o"},       8'(sda_o),       8'd1);
    chk({tag, "_rx_data"},     rx_data,         8'h00);
    chk({tag, "_rx_valid"},    8'(rx_valid),    8'd0);
    chk({tag, "_tx_req"},      8'(tx_req),      8'd0);
    chk({tag, "_tx_underrun"}, 8'(tx_underrun), 8'd0);
    chk({tag, "_busy"},        8'(busy),        8'd0);
    chk({tag, "_rw"},          8'(rw),          8'd0);
  endtask

  // Scoreboard monitor: every DUT pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid)    sb_pop(K_RX, rx_data, "rx_valid");
      if (tx_req)      sb_pop(K_TREQ, 8'h00, "tx_req");
      if (tx_underrun) sb_pop(K_UND, 8'h00, "tx_underrun");
      if (!sda_o)      sda_low_cnt++;
    end
  end

  // Local read-data source: answers tx_req with the next queued byte after reply_dly cycles
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_req && reply_q.size() > 0) begin
        cyc(reply_dly);
        tx_data  = reply_q.pop_front();
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctl_scl = 1'b1;
    ctl_sda = 1'b1;
    reset   = 1'b1;
    cyc(4);
    chk_reset_vals("rst");
    reset = 1'b0;
    cyc(4);

    // 1: write 0x3C to 0x50
    bus_start();
    wr_byte(8'hA0, 1'b0, "t1_addr_ack");
    chk("t1_busy_set", 8'(busy), 8'd1);
    expect_ev(K_RX, 8'h3C);
    wr_byte(8'h3C, 1'b0, "t1_data_ack");
    chk("t1_rx_data", rx_data, 8'h3C);
    bus_stop();
    cyc(2);
    chk("t1_busy_clear", 8'(busy), 8'd0);
    chk("t1_events_left", 8'(exp_q.size()), 8'd0);

    // 2: wrong address is ignored until STOP
    c0 = sda_low_cnt;
    bus_start();
    wr_byte(8'hA2, 1'b1, "t2_addr_nack");
    chk("t2_busy", 8'(busy), 8'd0);
    wr_byte(8'h55, 1'b1, "t2_ignored_nack");
    chk("t2_sda_never_low", 8'(sda_low_cnt - c0), 8'd0);
    bus_stop();
    chk("t2_events_left", 8'(exp_q.size()), 8'd0);

    // 3: read two bytes, ACK then NACK
    reply_q.push_back(8'h96);
    reply_q.push_back(8'h01);
    expect_ev(K_TREQ, 8'h00);
    bus_start();
    wr_byte(8'hA1, 1'b0, "t3_addr_ack");
    chk("t3_rw", 8'(rw), 8'd1);
    expect_ev(K_TREQ, 8'h00);
    rd_byte(8'h96, 1'b0, "t3_byte0");
    rd_byte(8'h01, 1'b1, "t3_byte1");
    rd_byte(8'hFF, 1'b1, "t3_wait_stop_released");
    bus_stop();
    cyc(2);
    chk("t3_busy_clear", 8'(busy), 8'd0);
    chk("t3_events_left", 8'(exp_q.size()), 8'd0);

    // 4: repeated START after 4 data bits discards the partial byte
    bus_start();
    wr_byte(8'hA0, 1'b0, "t4_addr1_ack");
    wr_bit(1'b1); wr_bit(1'b0); wr_bit(1'b1); wr_bit(1'b1);
    bus_start();
    wr_byte(8'hA0, 1'b0, "t4_addr2_ack");
    chk("t4_rx_data_kept", rx_data, 8'h3C);
    expect_ev(K_RX, 8'h81);
    wr_byte(8'h81, 1'b0, "t4_data_ack");
    bus_stop();
    chk("t4_events_left", 8'(exp_q.size()), 8'd0);

    // 5: read with no data supplied in time
`ifdef I2C_TARGET_CLK_STRETCH_EN
    reply_dly = 208;
    reply_q.push_back(8'h5A);
    expect_ev(K_TREQ, 8'h00);
    bus_start();
    wr_byte(8'hA1, 1'b0, "t5_addr_ack");
    chk("t5_stretch_start", 8'(scl_o), 8'd0);
    cyc(100);
    chk("t5_stretch_held", 8'(scl_o), 8'd0);
    rd_byte(8'h5A, 1'b1, "t5_stretched_byte");
    chk("t5_scl_released", 8'(scl_o), 8'd1);
    bus_stop();
    reply_dly = 1;
`else
    expect_ev(K_TREQ, 8'h00);
    expect_ev(K_UND, 8'h00);
    bus_start();
    wr_byte(8'hA1, 1'b0, "t5_addr_ack");
    rd_byte(8'hFF, 1'b1, "t5_default_byte");
    chk("t5_scl_o_const", 8'(scl_o), 8'd1);
    bus_stop();
`endif
    chk("t5_events_left", 8'(exp_q.size()), 8'd0);

    // 6: asynchronous reset while the address ACK is driven
    bus_start();
    wr_bit(1'b1); wr_bit(1'b0); wr_bit(1'b1); wr_bit(1'b0);
    wr_bit(1'b0); wr_bit(1'b0); wr_bit(1'b0); wr_bit(1'b0);
    ctl_sda = 1'b1;
    chk("t6_ack_driven", 8'(sda_o), 8'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_release", 8'(sda_o), 8'd1);
    cyc(2);
    chk_reset_vals("t6");
    ctl_scl = 1'b1;
    ctl_sda = 1'b1;
    cyc(4);
    reset = 1'b0;
    cyc(4);
    expect_ev(K_RX, 8'h7E);
    bus_start();
    wr_byte(8'hA0, 1'b0, "t6_recover_addr_ack");
    wr_byte(8'h7E, 1'b0, "t6_recover_data_ack");
    bus_stop();
    cyc(2);
    chk("t6_events_left", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
